ifu_fetch: RTL and testbench

Instruction fetch unit directly upstream of the IF/ID pipeline register. Owns the PC, issues in-order word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. Presents one {inst_addr_o, inst_o} pair per cycle to IF/ID. Applies ctrl jump redirects (flushing in-flight and buffered fetches) and ctrl hold stalls.

---
 rtl/ifu_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
//------------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit sitting directly in front of the IF/ID register.
// Owns the PC and issues in-order word fetches over a req/gnt/rvalid
// handshake. It remembers the address of every granted fetch and parks
// returned words in a small FIFO. The FIFO head is presented as
// {inst_addr_o, inst_o}. A ctrl jump flushes the FIFO and turns every
// in-flight response into a discard. A ctrl hold stops the FIFO from popping.
//
// Optional build macro:
//   FETCH_BYPASS_EN - when the FIFO is empty, a live response is presented in
//                     the same cycle it arrives instead of one cycle later.
//
// Parameters:
//   RESET_PC         PC loaded on reset
//   FIFO_DEPTH       fetch buffer entries (power of two, >= 2)
//   MAX_OUTSTANDING  granted-but-unanswered request limit (>= 1)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   jump_flag_i/addr_i   ctrl redirect request and target
//   hold_flag_i          ctrl stall, IF/ID not consuming this cycle
//   mem_req_o/addr_o     fetch request and word-aligned address
//   mem_gnt_i            request accepted this cycle
//   mem_rvalid_i/rdata_i in-order response
//   inst_valid_o         presented pair holds a real instruction
//   inst_addr_o, inst_o  presented PC / instruction (0 / NOP when invalid)
//------------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_o
);

   localparam logic [31:0] INST_NOP     = 32'h0000_0013;
   localparam int          PTR_W        = $clog2(FIFO_DEPTH);
   localparam int          CNT_W        = $clog2(FIFO_DEPTH + 1);
   localparam int          OUT_W        = $clog2(MAX_OUTSTANDING + 1);
   localparam int          AQ_W         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [31:0] FIFO_DEPTH_W = FIFO_DEPTH;
   localparam logic [31:0] MAX_OUT_W    = MAX_OUTSTANDING;
   localparam logic [AQ_W-1:0] AQ_LAST  = AQ_W'(MAX_OUTSTANDING - 1);

   logic [31:0]      pc_q;

   logic [31:0]      fifo_addr_q [FIFO_DEPTH];
   logic [31:0]      fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0] fifo_rd_ptr_q;
   logic [PTR_W-1:0] fifo_wr_ptr_q;
   logic [CNT_W-1:0] fifo_cnt_q;

   logic [31:0]      aq_addr_q [MAX_OUTSTANDING];
   logic [AQ_W-1:0]  aq_rd_ptr_q;
   logic [AQ_W-1:0]  aq_wr_ptr_q;

   logic [OUT_W-1:0] outstanding_q;
   logic [OUT_W-1:0] discard_cnt_q;

   logic             fifo_empty;
   logic             fifo_full;
   logic             fifo_push;
   logic             fifo_pop;
   logic             req_fire;
   logic             rsp_drop;
   logic             rsp_keep;
   logic [31:0]      rsp_addr;
   logic             credit_ok;

   assign fifo_empty = (fifo_cnt_q == '0);
   assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));

   // Count in-flight fetches against FIFO space so that every response is
   // guaranteed a slot even if IF/ID stalls indefinitely.
   assign credit_ok = ((32'(outstanding_q) + 32'(fifo_cnt_q)) < FIFO_DEPTH_W) &&
                      (32'(outstanding_q) < MAX_OUT_W);

   assign mem_req_o  = !rst && !jump_flag_i && credit_ok;
   assign mem_addr_o = pc_q;
   assign req_fire   = mem_req_o && mem_gnt_i;

   assign rsp_addr   = aq_addr_q[aq_rd_ptr_q];
   assign rsp_drop   = mem_rvalid_i && (discard_cnt_q != '0);
   // A response landing in a jump cycle belongs to the old stream.
   assign rsp_keep   = mem_rvalid_i && (discard_cnt_q == '0) && !jump_flag_i;

`ifdef FETCH_BYPASS_EN
   logic byp_hit;

   assign byp_hit = rsp_keep && fifo_empty;

   always_comb begin
      inst_valid_o = 1'b0;
      inst_addr_o  = 32'h0;
      inst_o       = INST_NOP;
      if (!fifo_empty) begin
         inst_valid_o = 1'b1;
         inst_addr_o  = fifo_addr_q[fifo_rd_ptr_q];
         inst_o       = fifo_data_q[fifo_rd_ptr_q];
      end else if (byp_hit) begin
         inst_valid_o = 1'b1;
         inst_addr_o  = rsp_addr;
         inst_o       = mem_rdata_i;
      end
   end

   // A bypassed word that IF/ID takes this cycle never enters the FIFO.
   assign fifo_push = rsp_keep && !(byp_hit && !hold_flag_i);
   assign fifo_pop  = !fifo_empty && !hold_flag_i;
`else
   always_comb begin
      inst_valid_o = 1'b0;
      inst_addr_o  = 32'h0;
      inst_o       = INST_NOP;
      if (!fifo_empty) begin
         inst_valid_o = 1'b1;
         inst_addr_o  = fifo_addr_q[fifo_rd_ptr_q];
         inst_o       = fifo_data_q[fifo_rd_ptr_q];
      end
   end

   assign fifo_push = rsp_keep;
   assign fifo_pop  = !fifo_empty && !hold_flag_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         fifo_rd_ptr_q <= '0;
         fifo_wr_ptr_q <= '0;
         fifo_cnt_q    <= '0;
         aq_rd_ptr_q   <= '0;
         aq_wr_ptr_q   <= '0;
         outstanding_q <= '0;
         discard_cnt_q <= '0;
      end else begin
         if (jump_flag_i) begin
            pc_q <= {jump_addr_i[31:2], 2'b00};
         end else if (req_fire) begin
            pc_q <= pc_q + 32'd4;
         end

         outstanding_q <= outstanding_q + OUT_W'(req_fire) - OUT_W'(mem_rvalid_i);

         // Every fetch still in flight after a jump is stale, including any
         // already marked for discard, so the new count is simply what
         // remains outstanding once this cycle's response is retired.
         if (jump_flag_i) begin
            discard_cnt_q <= outstanding_q - OUT_W'(mem_rvalid_i);
         end else if (rsp_drop) begin
            discard_cnt_q <= discard_cnt_q - 1'b1;
         end

         if (req_fire) begin
            aq_wr_ptr_q <= (aq_wr_ptr_q == AQ_LAST) ? '0 : aq_wr_ptr_q + 1'b1;
         end
         if (mem_rvalid_i) begin
            aq_rd_ptr_q <= (aq_rd_ptr_q == AQ_LAST) ? '0 : aq_rd_ptr_q + 1'b1;
         end

         if (jump_flag_i) begin
            fifo_rd_ptr_q <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_cnt_q    <= '0;
         end else begin
            if (fifo_push) begin
               fifo_wr_ptr_q <= fifo_wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
               fifo_rd_ptr_q <= fifo_rd_ptr_q + 1'b1;
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
         end
      end
   end

   // Storage arrays carry no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         aq_addr_q[aq_wr_ptr_q] <= pc_q;
      end
      if (!rst && !jump_flag_i && fifo_push) begin
         fifo_addr_q[fifo_wr_ptr_q] <= rsp_addr;
         fifo_data_q[fifo_wr_ptr_q] <= mem_rdata_i;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(fifo_push && fifo_full && !fifo_pop));
         assert (!(mem_rvalid_i && (outstanding_q == '0)));
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i  = 32'h0;
   logic        inst_valid_o;
   logic [31:0] inst_addr_o;
   logic [31:0] inst_o;

   int n_cmp = 0;
   int n_err = 0;

   int lat = 1;
   int cyc = 0;
   logic [31:0] mq_addr [$];
   int          mq_due  [$];
   logic [31:0] cons_addr [$];
   logic [31:0] cons_data [$];
   logic [31:0] gnt_log   [$];

   ifu_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .hold_flag_i  (hold_flag_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .inst_valid_o (inst_valid_o),
      .inst_addr_o  (inst_addr_o),
      .inst_o       (inst_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory model plus grant / consumption monitors, all sampled on posedge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         mq_addr.delete();
         mq_due.delete();
      end else begin
         if (mem_rvalid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         if (mem_req_o && mem_gnt_i) begin
            mq_addr.push_back(mem_addr_o);
            mq_due.push_back(cyc + lat);
            gnt_log.push_back(mem_addr_o);
         end
         if (inst_valid_o && !hold_flag_i && !jump_flag_i) begin
            cons_addr.push_back(inst_addr_o);
            cons_data.push_back(inst_o);
         end
      end
   end

   always @(negedge clk) begin
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mem_word(mq_addr[0]);
      end else begin
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = 32'h0;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_logs();
      cons_addr.delete();
      cons_data.delete();
      gnt_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 1'b0; mem_gnt_i = 1'b1;
      run(3);
      n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
      n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
      n_cmp++; if (inst_o !== NOP) begin n_err++; $display("FAIL rst_inst: got %h want %h", inst_o, NOP); end
      n_cmp++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
      rst = 1'b0;
      #1;
      n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", mem_req_o); end
      n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", mem_addr_o); end
   endtask

   task automatic test_stream();
      clear_logs();
      step();
      n_cmp++; if (inst_valid_o !== BYP) begin n_err++; $display("FAIL fill_c1_valid: got %b want %b", inst_valid_o, BYP); end
      step();
      n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL fill_c2_valid: got %b want 1", inst_valid_o); end
      run(15);
      n_cmp++;
      if (cons_addr.size() < 6) begin
         n_err++; $display("FAIL stream_count: got %0d want >=6", cons_addr.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++; if (cons_addr[i] !== 32'(4 * i)) begin n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", i, cons_addr[i], 32'(4 * i)); end
            n_cmp++; if (cons_data[i] !== mem_word(32'(4 * i))) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, cons_data[i], mem_word(32'(4 * i))); end
         end
      end
   endtask

   task automatic test_hold();
      logic [31:0] a;
      hold_flag_i = 1'b1;
      run(2);
      a = inst_addr_o;
      n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_valid: got %b want 1", inst_valid_o); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (inst_addr_o !== a) begin n_err++; $display("FAIL hold_addr_stable[%0d]: got %h want %h", i, inst_addr_o, a); end
      end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL hold_req_drop: got %b want 0", mem_req_o); end
      hold_flag_i = 1'b0;
      run(15);
      for (int i = 0; i < cons_addr.size(); i++) begin
         n_cmp++; if (cons_addr[i] !== 32'(4 * i)) begin n_err++; $display("FAIL hold_seq_addr[%0d]: got %h want %h", i, cons_addr[i], 32'(4 * i)); end
         n_cmp++; if (cons_data[i] !== mem_word(32'(4 * i))) begin n_err++; $display("FAIL hold_seq_data[%0d]: got %h want %h", i, cons_data[i], mem_word(32'(4 * i))); end
      end
      for (int i = 0; i < gnt_log.size(); i++) begin
         n_cmp++; if (gnt_log[i] !== 32'(4 * i)) begin n_err++; $display("FAIL hold_gnt[%0d]: got %h want %h", i, gnt_log[i], 32'(4 * i)); end
      end
   endtask

   task automatic test_jump_flush();
      bit found = 1'b0;
      lat = 3;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (mq_addr.size() == 2 && !mem_rvalid_i) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL jf_setup: got no 2-outstanding cycle want one within 40"); end
      clear_logs();
      jump_addr_i = 32'h0000_0103; jump_flag_i = 1'b1;
      #1;
      n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL jf_req_in_jump: got %b want 0", mem_req_o); end
      step();
      n_cmp++; if (mem_addr_o !== 32'h100) begin n_err++; $display("FAIL jf_new_addr: got %h want 00000100", mem_addr_o); end
      jump_flag_i = 1'b0;
      run(25);
      n_cmp++;
      if (gnt_log.size() < 1) begin n_err++; $display("FAIL jf_gnt_count: got 0 want >=1"); end
      else if (gnt_log[0] !== 32'h100) begin n_err++; $display("FAIL jf_gnt0: got %h want 00000100", gnt_log[0]); end
      n_cmp++;
      if (cons_addr.size() < 2) begin
         n_err++; $display("FAIL jf_count: got %0d want >=2", cons_addr.size());
      end else begin
         n_cmp++; if (cons_addr[0] !== 32'h100) begin n_err++; $display("FAIL jf_first_addr: got %h want 00000100", cons_addr[0]); end
         n_cmp++; if (cons_data[0] !== mem_word(32'h100)) begin n_err++; $display("FAIL jf_first_data: got %h want %h", cons_data[0], mem_word(32'h100)); end
         n_cmp++; if (cons_addr[1] !== 32'h104) begin n_err++; $display("FAIL jf_second_addr: got %h want 00000104", cons_addr[1]); end
      end
   endtask

   task automatic test_jump_hold();
      lat = 1;
      hold_flag_i = 1'b1;
      run(8);
      n_cmp++; if (inst_valid_o !== 1'b1) begin n_err++; $display("FAIL jh_full_valid: got %b want 1", inst_valid_o); end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL jh_full_noreq: got %b want 0", mem_req_o); end
      clear_logs();
      jump_addr_i = 32'h0000_0200; jump_flag_i = 1'b1;
      step();
      jump_flag_i = 1'b0;
      n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL jh_valid: got %b want 0", inst_valid_o); end
      n_cmp++; if (inst_o !== NOP) begin n_err++; $display("FAIL jh_inst: got %h want %h", inst_o, NOP); end
      n_cmp++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL jh_addr: got %h want 0", inst_addr_o); end
      hold_flag_i = 1'b0;
      run(10);
      n_cmp++;
      if (cons_addr.size() < 1) begin n_err++; $display("FAIL jh_count: got 0 want >=1"); end
      else if (cons_addr[0] !== 32'h200) begin n_err++; $display("FAIL jh_first_addr: got %h want 00000200", cons_addr[0]); end
   endtask

   task automatic test_jump_rvalid();
      bit found = 1'b0;
      lat = 3;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (mq_addr.size() == 2 && mem_rvalid_i) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL jr_setup: got no rvalid+2-outstanding cycle want one within 40"); end
      clear_logs();
      jump_addr_i = 32'h0000_0300; jump_flag_i = 1'b1;
      step();
      jump_flag_i = 1'b0;
      run(25);
      n_cmp++;
      if (cons_addr.size() < 2) begin
         n_err++; $display("FAIL jr_count: got %0d want >=2", cons_addr.size());
      end else begin
         n_cmp++; if (cons_addr[0] !== 32'h300) begin n_err++; $display("FAIL jr_first_addr: got %h want 00000300", cons_addr[0]); end
         n_cmp++; if (cons_data[0] !== mem_word(32'h300)) begin n_err++; $display("FAIL jr_first_data: got %h want %h", cons_data[0], mem_word(32'h300)); end
         n_cmp++; if (cons_addr[1] !== 32'h304) begin n_err++; $display("FAIL jr_second_addr: got %h want 00000304", cons_addr[1]); end
      end
      n_cmp++;
      if (gnt_log.size() < 1) begin n_err++; $display("FAIL jr_gnt_count: got 0 want >=1"); end
      else if (gnt_log[0] !== 32'h300) begin n_err++; $display("FAIL jr_gnt0: got %h want 00000300", gnt_log[0]); end
   endtask

   task automatic test_reset_midstream();
      bit found = 1'b0;
      lat = 3;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (mq_addr.size() == 2) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL rm_setup: got no 2-outstanding cycle want one within 40"); end
      rst = 1'b1;
      step();
      n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rm_addr: got %h want 0", mem_addr_o); end
      n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rm_req: got %b want 0", mem_req_o); end
      n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", inst_valid_o); end
      n_cmp++; if (inst_o !== NOP) begin n_err++; $display("FAIL rm_inst: got %h want %h", inst_o, NOP); end
      rst = 1'b0;
      #1;
      n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL rm_req_after: got %b want 1", mem_req_o); end
      clear_logs();
      lat = 1;
      jump_addr_i = 32'hFFFF_FFFC; jump_flag_i = 1'b1;
      step();
      jump_flag_i = 1'b0;
      run(12);
      n_cmp++;
      if (cons_addr.size() < 3) begin
         n_err++; $display("FAIL wrap_count: got %0d want >=3", cons_addr.size());
      end else begin
         n_cmp++; if (cons_addr[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_a0: got %h want fffffffc", cons_addr[0]); end
         n_cmp++; if (cons_data[0] !== mem_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_d0: got %h want %h", cons_data[0], mem_word(32'hFFFF_FFFC)); end
         n_cmp++; if (cons_addr[1] !== 32'h0) begin n_err++; $display("FAIL wrap_a1: got %h want 00000000", cons_addr[1]); end
         n_cmp++; if (cons_addr[2] !== 32'h4) begin n_err++; $display("FAIL wrap_a2: got %h want 00000004", cons_addr[2]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_jump_flush();
      test_jump_hold();
      test_jump_rvalid();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
